// File: rtl/dma_fifo_drain.sv
// ============================================================================
//  Module      : dma_fifo_drain
//  Description : Read-side DMA engine; drains a FWFT FIFO into a valid/ready
//                destination write port with incrementing or fixed address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_fifo_drain #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              rclk,
   input  logic              rrst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  xfer_len,
   input  logic              addr_incr,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rd_data,
   output logic              fifo_rd_en,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [LEN_W-1:0]  words_done
);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_XFER  = 2'd1;
   localparam logic [1:0] c_ST_FLUSH = 2'd2;
   localparam logic [1:0] c_ST_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(4);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [LEN_W-1:0]  r_remaining;
   logic              r_incr;
   logic              r_abort_pend;
   logic              w_accept;
   logic              w_start_ok;

   assign w_accept   = wr_valid && wr_ready;
   assign w_start_ok = (r_state == c_ST_IDLE) && start;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (start) begin
               w_state_nxt = (xfer_len != '0) ? c_ST_XFER : c_ST_DONE;
            end
         end
         c_ST_XFER: begin
            if ((r_remaining == '0) || abort) begin
               w_state_nxt = c_ST_FLUSH;
            end
         end
         c_ST_FLUSH: begin
            if (!wr_valid || w_accept) begin
               w_state_nxt = c_ST_DONE;
            end
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      fifo_rd_en = (r_state == c_ST_XFER) && !abort && (r_remaining != '0) &&
                   !fifo_empty && (!wr_valid || wr_ready);
      busy       = (r_state == c_ST_XFER) || (r_state == c_ST_FLUSH);
      done       = (r_state == c_ST_DONE);
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_cur_addr   <= '0;
         r_remaining  <= '0;
         r_incr       <= 1'b0;
         r_abort_pend <= 1'b0;
         wr_valid     <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         aborted      <= 1'b0;
         words_done   <= '0;
      end else begin
         if (w_start_ok) begin
            r_cur_addr   <= {dst_addr[ADDR_W-1:2], 2'b00};
            r_remaining  <= xfer_len;
            r_incr       <= addr_incr;
            r_abort_pend <= 1'b0;
            aborted      <= 1'b0;
            words_done   <= '0;
         end

         // A pop while the held beat is accepted keeps wr_valid high for back-to-back beats.
         if (fifo_rd_en) begin
            wr_data     <= fifo_rd_data;
            wr_addr     <= r_cur_addr;
            wr_valid    <= 1'b1;
            r_cur_addr  <= r_cur_addr + (r_incr ? c_ADDR_STEP : '0);
            r_remaining <= r_remaining - 1'b1;
         end else if (w_accept) begin
            wr_valid <= 1'b0;
         end

         if (w_accept) begin
            words_done <= words_done + 1'b1;
         end

         // Abort with words still outstanding marks the transfer as cut short.
         if ((r_state == c_ST_XFER) && abort && (r_remaining != '0)) begin
            r_abort_pend <= 1'b1;
         end

         if ((r_state == c_ST_FLUSH) && (w_state_nxt == c_ST_DONE)) begin
            aborted <= r_abort_pend;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dma_fifo_drain.sv
// ============================================================================
//  Module      : tb_dma_fifo_drain
//  Description : Directed scoreboard bench for dma_fifo_drain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_fifo_drain;

   logic        rclk = 1'b0;
   logic        rrst_n;
   logic        start;
   logic        abort;
   logic [31:0] dst_addr;
   logic [15:0] xfer_len;
   logic        addr_incr;
   logic        fifo_empty;
   logic [31:0] fifo_rd_data;
   logic        fifo_rd_en;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [15:0] words_done;

   int checks   = 0;
   int failures = 0;

   logic [31:0] fifo_mem [0:63];
   int          head = 0;
   int          tail = 0;
   logic        empty_force = 1'b0;
   logic        flush_req   = 1'b0;
   logic [63:0] exp_q [$];

   int          cyc       = 0;
   int          pops      = 0;
   int          acc_cnt   = 0;
   int          first_acc = 0;
   int          last_acc  = 0;
   int          done_cnt  = 0;
   logic        hold_pend = 1'b0;
   logic [31:0] hold_addr;
   logic [31:0] hold_data;

   dma_fifo_drain #(.DATA_W(32), .ADDR_W(32), .LEN_W(16)) dut (
      .rclk         (rclk),
      .rrst_n       (rrst_n),
      .start        (start),
      .abort        (abort),
      .dst_addr     (dst_addr),
      .xfer_len     (xfer_len),
      .addr_incr    (addr_incr),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .words_done   (words_done)
   );

   always #5 rclk = ~rclk;

   // FWFT FIFO model: data only presented while popped.
   assign fifo_empty   = (head == tail) || empty_force;
   assign fifo_rd_data = fifo_rd_en ? fifo_mem[head] : 32'h0;

   always @(posedge rclk) begin
      cyc <= cyc + 1;
      if (flush_req) head <= tail;
      else if (fifo_rd_en) head <= head + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: sampled at negedge, an observed valid&&ready is accepted at the next posedge.
   always @(negedge rclk) begin
      logic [63:0] e;
      if (!rrst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (fifo_rd_en) pops++;
         if (fifo_rd_en && fifo_empty) chk("rd_en_while_empty", 1, 0);
         if (hold_pend) begin
            chk("hold_valid", wr_valid, 1);
            chk("hold_addr", wr_addr, hold_addr);
            chk("hold_data", wr_data, hold_data);
         end
         hold_pend = wr_valid && !wr_ready;
         hold_addr = wr_addr;
         hold_data = wr_data;
         if (wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", wr_addr, e[63:32]);
               chk("wr_data", wr_data, e[31:0]);
            end
            if (acc_cnt == 0) first_acc = cyc;
            last_acc = cyc;
            acc_cnt++;
         end
         if (done) done_cnt++;
      end
   end

   task automatic load_word(input logic [31:0] a, input logic [31:0] d);
      fifo_mem[tail] = d;
      tail++;
      exp_q.push_back({a, d});
   endtask

   task automatic do_start(input logic [31:0] a, input logic [15:0] len, input logic inc);
      @(posedge rclk); #1;
      dst_addr = a; xfer_len = len; addr_incr = inc; start = 1'b1;
      @(posedge rclk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int done_cyc);
      bit seen = 0;
      done_cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge rclk);
         if (done) begin
            seen = 1;
            done_cyc = cyc;
            break;
         end
      end
      chk(tag, seen, 1);
   endtask

   initial begin
      int dc;
      int pop_base;
      int acc_base;
      int dn_base;
      bit ok;

      rrst_n = 1'b0; start = 1'b0; abort = 1'b0; dst_addr = '0; xfer_len = '0;
      addr_incr = 1'b0; wr_ready = 1'b0;
      repeat (3) @(posedge rclk);
      @(negedge rclk);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_words_done", words_done, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      @(posedge rclk); #1;
      rrst_n = 1'b1;

      // Incrementing burst, back-to-back
      for (int i = 0; i < 4; i++) load_word(32'h1000 + 4 * i, $urandom);
      wr_ready = 1'b1;
      acc_base = acc_cnt;
      do_start(32'h1000, 16'd4, 1'b1);
      wait_done("t1_done", dc);
      chk("t1_words_done", words_done, 4);
      chk("t1_aborted", aborted, 0);
      chk("t1_q_empty", exp_q.size(), 0);
      chk("t1_accepts", acc_cnt - acc_base, 4);
      chk("t1_back_to_back", last_acc - first_acc, 3);
      chk("t1_done_after_last", ((dc - last_acc) >= 1) && ((dc - last_acc) <= 2), 1);
      @(negedge rclk);
      chk("t1_done_pulse", done, 0);

      // Fixed address with mid-burst stall
      for (int i = 0; i < 3; i++) load_word(32'h2000, $urandom);
      pop_base = pops;
      acc_base = acc_cnt;
      do_start(32'h2000, 16'd3, 1'b0);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge rclk);
         if (acc_cnt - acc_base == 1) begin ok = 1; break; end
      end
      chk("t2_first_accept", ok, 1);
      @(posedge rclk); #1;
      wr_ready = 1'b0;
      repeat (2) @(posedge rclk);
      #1 wr_ready = 1'b1;
      wait_done("t2_done", dc);
      chk("t2_pops", pops - pop_base, 3);
      chk("t2_words_done", words_done, 3);
      chk("t2_q_empty", exp_q.size(), 0);

      // FIFO empty for 5 cycles after start
      empty_force = 1'b1;
      for (int i = 0; i < 8; i++) load_word(32'h4000 + 4 * i, $urandom);
      do_start(32'h4000, 16'd8, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge rclk);
         chk("t3_no_pop_empty", fifo_rd_en, 0);
      end
      @(posedge rclk); #1;
      empty_force = 1'b0;
      wait_done("t3_done", dc);
      chk("t3_words_done", words_done, 8);
      chk("t3_q_empty", exp_q.size(), 0);

      // Abort with one write pending
      for (int i = 0; i < 6; i++) load_word(32'h5000 + 4 * i, $urandom);
      pop_base = pops;
      do_start(32'h5000, 16'd6, 1'b1);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge rclk); #1;
         if (words_done == 16'd2) begin ok = 1; break; end
      end
      chk("t4_two_accepts", ok, 1);
      chk("t4_pending_valid", wr_valid, 1);
      abort = 1'b1;
      wait_done("t4_done", dc);
      chk("t4_aborted", aborted, 1);
      chk("t4_words_done", words_done, 3);
      chk("t4_pops", pops - pop_base, 3);
      chk("t4_unwritten", exp_q.size(), 3);
      exp_q.delete();
      @(posedge rclk); #1;
      abort = 1'b0;
      flush_req = 1'b1;
      @(posedge rclk); #1;
      flush_req = 1'b0;

      // Zero-length transfer; start in DONE ignored
      pop_base = pops;
      dn_base  = done_cnt;
      @(posedge rclk); #1;
      dst_addr = 32'h6000; xfer_len = 16'd0; addr_incr = 1'b1; start = 1'b1;
      @(posedge rclk); #1;
      xfer_len = 16'd5;
      @(negedge rclk);
      chk("t5_done_pulse", done, 1);
      chk("t5_aborted_clr", aborted, 0);
      chk("t5_words_clr", words_done, 0);
      @(posedge rclk); #1;
      start = 1'b0;
      @(negedge rclk);
      chk("t5_done_low", done, 0);
      chk("t5_ignored_busy", busy, 0);
      @(negedge rclk);
      chk("t5_still_idle", busy, 0);
      chk("t5_pops", pops - pop_base, 0);
      chk("t5_one_done", done_cnt - dn_base, 1);

      // Address wrap past the top
      load_word(32'hFFFF_FFFC, $urandom);
      load_word(32'h0000_0000, $urandom);
      do_start(32'hFFFF_FFFC, 16'd2, 1'b1);
      wait_done("t6_done", dc);
      chk("t6_words_done", words_done, 2);
      chk("t6_q_empty", exp_q.size(), 0);

      // Reset in the middle of a stalled transfer
      for (int i = 0; i < 4; i++) load_word(32'h7000 + 4 * i, $urandom);
      wr_ready = 1'b0;
      do_start(32'h7000, 16'd4, 1'b1);
      repeat (3) @(posedge rclk);
      #1;
      chk("t7_busy_before", busy, 1);
      chk("t7_valid_before", wr_valid, 1);
      dn_base = done_cnt;
      rrst_n = 1'b0;
      @(negedge rclk);
      chk("t7_rst_valid", wr_valid, 0);
      chk("t7_rst_addr", wr_addr, 0);
      chk("t7_rst_data", wr_data, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_done", done, 0);
      chk("t7_rst_words", words_done, 0);
      chk("t7_rst_rd_en", fifo_rd_en, 0);
      exp_q.delete();
      @(posedge rclk); #1;
      rrst_n = 1'b1;
      repeat (4) @(negedge rclk);
      chk("t7_no_done", done_cnt - dn_base, 0);
      chk("t7_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
